// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler.
// It has a synchronous load, a one-cycle step tick and a wrap carry, all driven from flops.
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_tick,
  output logic                  o_carry
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]         r_pre;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_tick;
  logic                  r_carry;

  logic [4*DIGITS-1:0]   w_step_val;
  logic [4*DIGITS-1:0]   w_load_clean;
  logic                  w_chain;

  // Non-decimal nibbles are loaded as zero so the count never leaves BCD.
  function automatic logic [3:0] nib_clean(input logic [3:0] nib);
    logic [3:0] res;
    if (nib > 4'd9) begin
      res = 4'd0;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Next-step value: ripple increment/borrow from digit 0; w_chain left high means every digit wrapped.
  always_comb begin
    w_step_val   = r_bcd;
    w_load_clean = '0;
    w_chain      = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      w_load_clean[4*d +: 4] = nib_clean(i_load_val[4*d +: 4]);
      if (w_chain) begin
        if (i_up) begin
          if (r_bcd[4*d +: 4] >= 4'd9) begin
            w_step_val[4*d +: 4] = 4'd0;
          end else begin
            w_step_val[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
            w_chain = 1'b0;
          end
        end else begin
          if (r_bcd[4*d +: 4] == 4'd0) begin
            w_step_val[4*d +: 4] = 4'd9;
          end else if (r_bcd[4*d +: 4] > 4'd9) begin
            w_step_val[4*d +: 4] = 4'd9;
            w_chain = 1'b0;
          end else begin
            w_step_val[4*d +: 4] = r_bcd[4*d +: 4] - 4'd1;
            w_chain = 1'b0;
          end
        end
      end else begin
        w_step_val[4*d +: 4] = r_bcd[4*d +: 4];
      end
    end
  end

  // Prescaler, count and pulse registers; the priority is reset, then load, then enabled counting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre   <= '0;
      r_bcd   <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_pre   <= '0;
      r_bcd   <= w_load_clean;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (i_en) begin
      if (r_pre == PRE_MAX) begin
        r_pre   <= '0;
        r_bcd   <= w_step_val;
        r_tick  <= 1'b1;
        r_carry <= w_chain;
      end else begin
        r_pre   <= r_pre + PW'(1);
        r_tick  <= 1'b0;
        r_carry <= 1'b0;
      end
    end else begin
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end
  end

  assign o_bcd   = r_bcd;
  assign o_tick  = r_tick;
  assign o_carry = r_carry;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIGITS=2, TICK_DIV=4.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd;
  logic       tick;
  logic       carry;

  int tests;
  int fails;

  bcd_updown_counter #(.DIGITS(2), .TICK_DIV(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up       (up),
    .i_load     (load),
    .i_load_val (load_val),
    .o_bcd      (bcd),
    .o_tick     (tick),
    .o_carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_bcd, input logic e_tick,
                           input logic e_carry);
    check({tag, ".bcd"},   bcd,          e_bcd);
    check({tag, ".tick"},  {7'd0, tick},  {7'd0, e_tick});
    check({tag, ".carry"}, {7'd0, carry}, {7'd0, e_carry});
  endtask

  initial begin
    logic [7:0] eb;
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    repeat (2) @(negedge clk);
    check_all("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Count up from zero: steps on cycles 4, 8 and 12.
    en = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      eb = 8'(k / 4);
      check_all($sformatf("up_c%0d", k), eb, (k % 4) == 0, 1'b0);
    end

    // Up-wrap 98 -> 99 -> 00 with carry on the wrapping edge only.
    en       = 1'b0;
    load_val = 8'h98;
    load     = 1'b1;
    @(negedge clk);
    check_all("load98", 8'h98, 1'b0, 1'b0);
    load = 1'b0;
    en   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      eb = (k < 4) ? 8'h98 : ((k < 8) ? 8'h99 : 8'h00);
      check_all($sformatf("wrapup_c%0d", k), eb, (k % 4) == 0, k == 8);
    end

    // Down-wrap 00 -> 99, then 99 -> 98 without carry.
    en       = 1'b0;
    load_val = 8'h00;
    load     = 1'b1;
    @(negedge clk);
    check_all("load00", 8'h00, 1'b0, 1'b0);
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      eb = (k < 4) ? 8'h00 : ((k < 8) ? 8'h99 : 8'h98);
      check_all($sformatf("wrapdn_c%0d", k), eb, (k % 4) == 0, k == 4);
    end

    // Enable gap of 5 cycles stretches the period: step lands on cycle 9.
    for (int k = 1; k <= 9; k++) begin
      en = (k <= 2 || k >= 8);
      @(negedge clk);
      check_all($sformatf("gap_c%0d", k), (k == 9) ? 8'h97 : 8'h98, k == 9, 1'b0);
    end

    // Load with a non-decimal digit: only that digit is zeroed.
    en       = 1'b0;
    load_val = 8'hA5;
    load     = 1'b1;
    @(negedge clk);
    check_all("loadA5", 8'h05, 1'b0, 1'b0);
    load = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    repeat (3) @(negedge clk);
    check_all("pre3", 8'h05, 1'b0, 1'b0);
    // Load on the edge where pre reaches 3 must beat the step.
    load_val = 8'h5B;
    load     = 1'b1;
    @(negedge clk);
    check_all("load_wins", 8'h50, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_all($sformatf("postload_c%0d", k), (k == 4) ? 8'h51 : 8'h50, k == 4, 1'b0);
    end

    // Reach 37 with tick high, then pulse reset between edges.
    en       = 1'b0;
    load_val = 8'h36;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    repeat (4) @(negedge clk);
    check_all("pre_rst", 8'h37, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_all($sformatf("postrst_c%0d", k), (k == 4) ? 8'h01 : 8'h00, k == 4, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with a built-in prescaler. It steps once per prescaler period, for example once per second at 100 MHz. It generalises the single-digit decade counter used on the ZedBoard demos and adds digit count, direction, enable, synchronous load, a tick pulse and a wrap carry. Its outputs drive seven-segment or LED display decoders directly.

## Interface
- DIGITS, 4, number of BCD digits; digit 0 is least significant and occupies bcd[3:0].
- TICK_DIV, 100000000, clk cycles per count step; legal range ≥ 1.
- clk  input  1  system clock, 100 MHz on ZedBoard.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  prescaler and count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  4*DIGITS  BCD value to load.
- bcd  output  4*DIGITS  current count, registered.
- tick  output  1  one-cycle pulse on every count step, registered.
- carry  output  1  one-cycle pulse on wrap-around, registered.

One clock (clk). Reset rst is asynchronous and active-high.

## Operation
- Prescaler: internal counter pre, width max(1, $clog2(TICK_DIV)), range 0..TICK_DIV-1.
- Priority per clk edge: rst > load > en-gated counting > hold.
- rst asserted:
  - Immediately forces bcd = 0, tick = 0, carry = 0 and pre = 0, with no dependence on clk.
  - All registers hold these values while rst is high.
- load = 1:
  - bcd <= load_val and pre <= 0.
  - tick <= 0 and carry <= 0.
  - Any load_val nibble > 9 is loaded as 0 for that digit only; the other digits load unchanged.
  - load overrides en.
- en = 1, load = 0:
  - If pre == TICK_DIV-1: pre <= 0, bcd takes one step, tick <= 1.
  - Otherwise pre <= pre+1 and tick <= 0.
- en = 0, load = 0: pre, bcd and every digit hold; tick <= 0 and carry <= 0.
- Step up:
  - Digit 0 increments. A digit at 9 becomes 0 and propagates the increment to the next digit.
  - All digits at 9 produce all zeros, and carry <= 1 with tick.
- Step down:
  - Digit 0 decrements. A digit at 0 becomes 9 and propagates the borrow to the next digit.
  - All digits at 0 produce all nines, and carry <= 1 with tick.
- carry is 0 on every non-wrapping step.
- up is sampled only on the stepping edge. Changing up mid-period does not reset pre.
- bcd never holds a nibble > 9 under any input sequence.
- TICK_DIV = 1: a step occurs on every clk edge while en = 1, and tick stays high continuously.

## Timing
- Reset values: bcd = 0, tick = 0, carry = 0, pre = 0.
- Step latency:
  - From en rising with pre = 0, the first tick and bcd change occur on the TICK_DIV-th enabled edge.
  - bcd, tick and carry all update on the same edge.
- Later steps occur every TICK_DIV enabled cycles.
- Deasserting en for N cycles stretches the period by exactly N cycles.
- load:
  - bcd shows load_val one edge after load is sampled high.
  - The next step occurs TICK_DIV enabled cycles after that edge.
- load on the same edge pre reaches TICK_DIV-1: load wins, no step, tick = 0.
- rst released mid-operation: counting restarts from pre = 0, and the first step comes TICK_DIV enabled edges after release.
- rst asserted while tick or carry is high: both drop asynchronously.
- Outputs are glitch-free because every output comes directly from a flop.

## Test plan
Bench parameters: DIGITS=2, TICK_DIV=4.
- Reset, then en=1, up=1 for 12 cycles: bcd 00→01→02→03 on cycles 4, 8 and 12. tick pulses once per 4 cycles. carry stays 0.
- load_val=8'h98, load, then en=1, up=1 for 8 cycles: bcd 98→99→00. carry=1 only on the 99→00 edge, coincident with tick.
- load_val=8'h00, load, en=1, up=0 for 4 cycles: bcd 00→99, carry=1 and tick=1 on that edge. A further 4 cycles: 99→98, carry=0.
- en=1 for 2 cycles, en=0 for 5 cycles, en=1: bcd holds through the gap. The next step lands 2 enabled cycles after re-enable, 9 cycles total after start.
- load_val=8'hA5: bcd = 8'h05. Assert load on the cycle pre=3: no step and tick=0. The next step comes 4 enabled cycles after the load.
- With bcd=8'h37 and tick high, pulse rst between clk edges: bcd=00 and tick=0 before the next edge. After release, the first step comes on the 4th enabled edge.
